// File: rtl/regfile_mp_pkg.sv
// Shared defaults and types for the multi-port integer register file.
// Default geometry matches the RV32 integer file; a0 is x10.
// Types are sized for the default geometry.
package rf_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_A0_IDX     = 10;
  localparam int DEF_AW         = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]         reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback/issue bundle of the register file.
// master drives addresses, writebacks and issues; slave returns read data, busy and a0.
// All slave outputs are combinational except a0, which is registered.
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_READ-1:0][AW-1:0]          rd_addr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]                  rd_busy;
  logic [NUM_WRITE-1:0]                 wr_en;
  logic [NUM_WRITE-1:0][AW-1:0]         wr_addr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
  logic                                 iss_en;
  logic [AW-1:0]                        iss_addr;
  logic [DATA_WIDTH-1:0]                a0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, a0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, a0
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback, set wins on a collision.
// Busy state changes on the edge after issue/writeback; entry 0 is never busy.
// Issue and writeback paths are independent; stalls are gated upstream.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int NUM_WRITE = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                iss_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]         iss_addr_i,
  input  logic [NUM_WRITE-1:0]                wr_en_i,
  input  logic [NUM_WRITE-1:0][$clog2(NUM_REGS)-1:0] wr_addr_i,
  output logic [NUM_REGS-1:0]                 busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clears from every writeback first, then the issue set overrides.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
        busy_d[wr_addr_i[w]] = 1'b0;
      end
    end
    if (iss_en_i && (iss_addr_i != '0)) begin
      busy_d[iss_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register; reset leaves nothing pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, busy scoreboard and exported a0.
// Reads and rd_busy are combinational (0 cycles); writes land in storage on the edge.
// No backpressure: every enabled write/issue is accepted unless rst is high.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int A0_IDX     = DEF_A0_IDX
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_WRITE-1:0]  wr_live;

  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data_mux;
  logic [NUM_READ-1:0]                 rd_busy_mux;

  // Writes during reset are ignored, so they must not bypass either.
  assign wr_live = bus.wr_en & {NUM_WRITE{~rst}};

  // Next storage: apply ports in ascending order so the highest index wins a clash.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_live[w] && (bus.wr_addr[w] != '0)) begin
        regs_d[bus.wr_addr[w]] = bus.wr_data[w];
      end
    end
    regs_d[0] = '0;
  end

  // Storage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_WRITE (NUM_WRITE)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (bus.iss_en),
    .iss_addr_i (bus.iss_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .busy_o     (busy)
  );

  // Read muxes: storage, overridden by the highest matching live write, x0 forced to zero.
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rd_data_mux[r] = regs_q[bus.rd_addr[r]];
      rd_busy_mux[r] = busy[bus.rd_addr[r]];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_live[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
          rd_data_mux[r] = bus.wr_data[w];
          rd_busy_mux[r] = 1'b0;
        end
      end
      if (bus.rd_addr[r] == '0) begin
        rd_data_mux[r] = '0;
        rd_busy_mux[r] = 1'b0;
      end
    end
  end

  assign bus.rd_data = rd_data_mux;
  assign bus.rd_busy = rd_busy_mux;
  // a0 comes straight from storage, so it already trails the write by one edge.
  assign bus.a0      = regs_q[A0_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks of reset, x0, bypass, port priority, scoreboard and a0 timing.
// Inputs change 1ns after the rising edge; outputs are sampled 1-3ns later.
// Two writeback ports are instantiated to cover write-port priority.
module tb_regfile_mp;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  regfile_mp_if #(.NUM_WRITE(2)) bus ();

  regfile_mp #(.NUM_WRITE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic wr(input int port, input reg_addr_t a, input reg_data_t d);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = a;
    bus.wr_data[port] = d;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    idle();
    bus.rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd10;
    #1;
    check("reset_rd0", bus.rd_data[0], 32'h0);
    check("reset_busy0", {31'b0, bus.rd_busy[0]}, 32'h0);
    check("reset_a0", bus.a0, 32'h0);

    // Mid-cycle reset after a write and an issue
    wr(0, 5'd5, 32'hDEADBEEF);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
    tick();
    idle();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd6;
    #1;
    check("pre_rst_x5", bus.rd_data[0], 32'hDEADBEEF);
    check("pre_rst_busy6", {31'b0, bus.rd_busy[1]}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_x5", bus.rd_data[0], 32'h0);
    check("rst_x6", bus.rd_data[1], 32'h0);
    check("rst_busy6", {31'b0, bus.rd_busy[1]}, 32'h0);
    check("rst_a0", bus.a0, 32'h0);
    tick();
    rst = 1'b0;

    // x0 protection
    wr(0, 5'd0, 32'h1234);
    bus.rd_addr[0] = 5'd0;
    #1;
    check("x0_bypass", bus.rd_data[0], 32'h0);
    tick();
    idle();
    #1;
    check("x0_stored", bus.rd_data[0], 32'h0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    tick();
    idle();
    #1;
    check("x0_busy", {31'b0, bus.rd_busy[0]}, 32'h0);

    // Same-cycle bypass on both read ports
    wr(0, 5'd7, 32'hCAFEF00D);
    bus.rd_addr[0] = 5'd7;
    bus.rd_addr[1] = 5'd7;
    #1;
    check("byp_rd0", bus.rd_data[0], 32'hCAFEF00D);
    check("byp_rd1", bus.rd_data[1], 32'hCAFEF00D);
    tick();
    idle();
    #1;
    check("stored_rd0", bus.rd_data[0], 32'hCAFEF00D);
    check("stored_rd1", bus.rd_data[1], 32'hCAFEF00D);

    // Write-port priority
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    bus.rd_addr[0] = 5'd3;
    #1;
    check("prio_bypass", bus.rd_data[0], 32'h22);
    tick();
    idle();
    #1;
    check("prio_stored", bus.rd_data[0], 32'h22);

    // Scoreboard
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    bus.rd_addr[0] = 5'd9;
    #1;
    check("sb_same_cycle", {31'b0, bus.rd_busy[0]}, 32'h0);
    tick();
    idle();
    #1;
    check("sb_set", {31'b0, bus.rd_busy[0]}, 32'h1);
    wr(0, 5'd9, 32'h55);
    #1;
    check("sb_wb_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    check("sb_wb_data", bus.rd_data[0], 32'h55);
    tick();
    idle();
    #1;
    check("sb_cleared", {31'b0, bus.rd_busy[0]}, 32'h0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    wr(0, 5'd9, 32'h66);
    #1;
    check("sb_coll_now", {31'b0, bus.rd_busy[0]}, 32'h0);
    tick();
    idle();
    #1;
    check("sb_set_wins", {31'b0, bus.rd_busy[0]}, 32'h1);
    check("sb_coll_data", bus.rd_data[0], 32'h66);
    wr(1, 5'd9, 32'h77);
    tick();
    idle();
    #1;
    check("sb_clr_port1", {31'b0, bus.rd_busy[0]}, 32'h0);
    check("sb_port1_data", bus.rd_data[0], 32'h77);

    // a0 trails the write by one edge
    wr(0, 5'd10, 32'hA5A5A5A5);
    #1;
    check("a0_write_cycle", bus.a0, 32'h0);
    tick();
    idle();
    #1;
    check("a0_next_cycle", bus.a0, 32'hA5A5A5A5);

    // Reset again; afterwards only bypass supplies data
    rst = 1'b1;
    bus.rd_addr[0] = 5'd10;
    #1;
    check("rst2_a0", bus.a0, 32'h0);
    check("rst2_x10", bus.rd_data[0], 32'h0);
    tick();
    rst = 1'b0;
    wr(0, 5'd10, 32'h12345678);
    #1;
    check("post_rst_bypass", bus.rd_data[0], 32'h12345678);
    idle();
    #1;
    check("post_rst_storage", bus.rd_data[0], 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
